// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: mode encodings,
// pipeline latency and the offset-binary centre helper.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_TRI    = 2'd3
  } dds_mode_e;

  localparam int unsigned DDS_LAT = 3;

  function automatic int unsigned centre_val(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Synchronous one-cycle sine ROM, 2^DATA_W entries of DATA_W-bit offset binary.
// Contents are generated arithmetically (Bhaskara sine form, exact at quarter points).
module sine_lut #(
  parameter int unsigned DATA_W   = 10,
  parameter string       LUT_INIT = "sine_lut.mif"
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  if (LUT_INIT == "") begin : g_init_chk
    $error("sine_lut: LUT_INIT must name the table image");
  end

  function automatic logic [DATA_W-1:0] sine_at(input logic [DATA_W-1:0] p);
    longint h, u, a, num, den, mag;
    h   = longint'(1) << (DATA_W - 1);
    u   = longint'(p[DATA_W-2:0]);
    a   = h - 1;
    num = 16 * a * u * (h - u);
    den = 5 * h * h - 4 * u * (h - u);
    mag = num / den;
    return p[DATA_W-1] ? DATA_W'(h - mag) : DATA_W'(h + mag);
  endfunction

  always_ff @(posedge clk) begin
    data <= sine_at(addr);
  end

endmodule

// File: rtl/dds_wavegen.sv
// Phase-accumulator waveform generator: tick-paced 3-stage pipeline producing
// one attenuated offset-binary sample per accepted tick.
module dds_wavegen
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned DATA_W   = 10,
  parameter string       LUT_INIT = "sine_lut.mif"
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               tick,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         mode,
  input  logic [2:0]         atten,
  input  logic               update,
  input  logic               phase_clr,
  input  logic               clr_overrun,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  localparam logic [DATA_W-1:0] CENTRE = DATA_W'(centre_val(DATA_W));

  logic [PHASE_W-1:0] acc, act_freq, pend_freq, eff_freq;
  dds_mode_e          act_mode, pend_mode, eff_mode, mode_d2;
  logic [2:0]         act_atten, pend_atten, eff_atten, atten_d2;
  logic               update_pend, clr_pend, accept;
  logic [DDS_LAT-1:0] vpipe;
  logic [DATA_W-1:0]  p1, p2, lut_q, raw, next_sample;
  logic signed [DATA_W:0] diff, shifted;

  assign busy         = |vpipe;
  assign sample_valid = vpipe[DDS_LAT-1];
  assign accept       = tick && !busy;
  assign p1           = acc[PHASE_W-1 -: DATA_W];

  // Same-cycle update bypasses the pending registers so that tick uses it.
  always_comb begin
    eff_freq  = act_freq;
    eff_mode  = act_mode;
    eff_atten = act_atten;
    if (update) begin
      eff_freq  = freq_word;
      eff_mode  = dds_mode_e'(mode);
      eff_atten = atten;
    end else if (update_pend) begin
      eff_freq  = pend_freq;
      eff_mode  = pend_mode;
      eff_atten = pend_atten;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      act_freq    <= '0;
      act_mode    <= MODE_SINE;
      act_atten   <= '0;
      pend_freq   <= '0;
      pend_mode   <= MODE_SINE;
      pend_atten  <= '0;
      update_pend <= 1'b0;
      clr_pend    <= 1'b0;
    end else begin
      if (update) begin
        pend_freq   <= freq_word;
        pend_mode   <= dds_mode_e'(mode);
        pend_atten  <= atten;
        update_pend <= 1'b1;
      end
      if (phase_clr) clr_pend <= 1'b1;
      if (accept) begin
        act_freq    <= eff_freq;
        act_mode    <= eff_mode;
        act_atten   <= eff_atten;
        acc         <= ((clr_pend || phase_clr) ? '0 : acc) + eff_freq;
        update_pend <= 1'b0;
        clr_pend    <= 1'b0;
      end
    end
  end

  sine_lut #(
    .DATA_W  (DATA_W),
    .LUT_INIT(LUT_INIT)
  ) u_lut (
    .clk (sysclk),
    .addr(p1),
    .data(lut_q)
  );

  always_comb begin
    raw = p2;
    unique case (mode_d2)
      MODE_SINE:   raw = lut_q;
      MODE_SAW:    raw = p2;
      MODE_SQUARE: raw = p2[DATA_W-1] ? '0 : '1;
      MODE_TRI:    raw = p2[DATA_W-1] ? ~{p2[DATA_W-2:0], 1'b0} : {p2[DATA_W-2:0], 1'b0};
      default:     raw = p2;
    endcase
    diff        = $signed({1'b0, raw}) - $signed({1'b0, CENTRE});
    shifted     = diff >>> atten_d2;
    next_sample = CENTRE + DATA_W'(shifted);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      vpipe    <= '0;
      p2       <= '0;
      mode_d2  <= MODE_SINE;
      atten_d2 <= '0;
      sample   <= CENTRE;
      overrun  <= 1'b0;
    end else begin
      vpipe    <= {vpipe[DDS_LAT-2:0], accept};
      p2       <= p1;
      mode_d2  <= act_mode;
      atten_d2 <= act_atten;
      if (vpipe[1]) sample <= next_sample;
      if (tick && busy)     overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_wavegen.sv
// Self-checking bench for dds_wavegen: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_dds_wavegen;
  import dds_pkg::*;

  localparam int unsigned PHASE_W = 16;
  localparam int unsigned DATA_W  = 10;

  logic               sysclk = 1'b0;
  logic               reset  = 1'b1;
  logic               tick = 1'b0, update = 1'b0, phase_clr = 1'b0, clr_overrun = 1'b0;
  logic [PHASE_W-1:0] freq_word = '0;
  logic [1:0]         mode = '0;
  logic [2:0]         atten = '0;
  logic [DATA_W-1:0]  sample;
  logic               sample_valid, busy, overrun;

  always #10 sysclk = ~sysclk;

  dds_wavegen #(
    .PHASE_W (PHASE_W),
    .DATA_W  (DATA_W),
    .LUT_INIT("sine_lut.mif")
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .tick        (tick),
    .freq_word   (freq_word),
    .mode        (mode),
    .atten       (atten),
    .update      (update),
    .phase_clr   (phase_clr),
    .clr_overrun (clr_overrun),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted ticks produce a (due cycle, value) entry.
  typedef struct { int due; int val; } exp_t;
  exp_t m_q[$];
  int   m_acc, m_afreq, m_amode, m_aatt, m_pfreq, m_pmode, m_patt;
  int   m_busy_until, m_sample, cyc;
  bit   m_upd, m_clr, m_ovr, m_valid;

  function automatic void model_reset();
    m_q.delete();
    m_acc = 0; m_afreq = 0; m_amode = 0; m_aatt = 0;
    m_pfreq = 0; m_pmode = 0; m_patt = 0;
    m_upd = 0; m_clr = 0; m_ovr = 0; m_valid = 0;
    m_busy_until = -10; m_sample = 512;
  endfunction

  function automatic int sine_ref(input int p);
    real s;
    s = 511.0 * $sin(2.0 * 3.14159265358979 * p / 1024.0);
    return 512 + int'($floor(s + 0.5));
  endfunction

  function automatic int wave(input int md, input int p);
    case (md)
      0:       return sine_ref(p);
      1:       return p;
      2:       return (p < 512) ? 1023 : 0;
      default: return (p < 512) ? 2 * p : 1023 - ((2 * p) % 1024);
    endcase
  endfunction

  function automatic int atten_fn(input int raw, input int k);
    int d, div;
    d   = raw - 512;
    div = 1 << k;
    if (d >= 0) return 512 + d / div;
    return 512 - ((-d + div - 1) / div);
  endfunction

  function automatic void model_edge(input bit t, input bit u, input int fw, input int md,
                                     input int at, input bit pc, input bit co);
    int n;
    bit ok;
    n  = cyc;
    ok = t && !(n <= m_busy_until);
    if (t && !ok) m_ovr = 1;
    else if (co)  m_ovr = 0;
    if (u) begin
      m_pfreq = fw & 'hFFFF; m_pmode = md; m_patt = at; m_upd = 1;
    end
    if (pc) m_clr = 1;
    if (ok) begin
      if (m_upd) begin
        m_afreq = m_pfreq; m_amode = m_pmode; m_aatt = m_patt;
      end
      m_acc = ((m_clr ? 0 : m_acc) + m_afreq) % 65536;
      m_upd = 0; m_clr = 0;
      m_q.push_back('{due: n + 2, val: atten_fn(wave(m_amode, m_acc / 64), m_aatt)});
      m_busy_until = n + 3;
    end
    m_valid = 0;
    if (m_q.size() > 0 && m_q[0].due == n) begin
      m_valid  = 1;
      m_sample = m_q[0].val;
      void'(m_q.pop_front());
    end
  endfunction

  task automatic drive(input bit t, input bit u, input int fw, input int md,
                       input int at, input bit pc, input bit co);
    tick = t; update = u; phase_clr = pc; clr_overrun = co;
    freq_word = fw[PHASE_W-1:0]; mode = md[1:0]; atten = at[2:0];
    @(posedge sysclk);
    model_edge(t, u, fw, md, at, pc, co);
    #1;
    check_eq("valid",   {31'd0, sample_valid}, {31'd0, m_valid});
    check_eq("sample",  {22'd0, sample}, m_sample);
    check_eq("busy",    {31'd0, busy}, (cyc < m_busy_until) ? 1 : 0);
    check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    tick = 0; update = 0; phase_clr = 0; clr_overrun = 0;
    cyc++;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int fw, input int md, input int at, input bit pc);
    drive(0, 1, fw, md, at, pc, 0);
  endtask

  // Tick, then confirm the sample lands exactly two edges later.
  task automatic tk(input int exp);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    check_eq("directed_sample", {22'd0, sample}, exp);
    check_eq("directed_valid", {31'd0, sample_valid}, 1);
    idle();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    @(posedge sysclk);
    @(posedge sysclk);
    #1;
    check_eq("rst_sample",  {22'd0, sample}, 512);
    check_eq("rst_valid",   {31'd0, sample_valid}, 0);
    check_eq("rst_busy",    {31'd0, busy}, 0);
    check_eq("rst_overrun", {31'd0, overrun}, 0);
    @(negedge sysclk);
    reset = 0;

    cfg(1024, 1, 0, 0);  tk(16);  tk(32);  tk(48);
    cfg(1024, 1, 0, 1);  tk(16);  cfg(2048, 1, 0, 0);  tk(48);
    cfg(32768, 1, 0, 1); tk(512); tk(0);
    cfg(32768, 2, 0, 1); tk(0);   tk(1023);
    cfg(1024, 1, 1, 1);  tk(264);
    cfg(1024, 1, 7, 1);  tk(508);

    drive(1, 0, 0, 0, 0, 0, 0);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0);
    check_eq("ovr_set", {31'd0, overrun}, 1);
    idle(); idle();
    drive(0, 0, 0, 0, 0, 0, 1);
    check_eq("ovr_clr", {31'd0, overrun}, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    check_eq("ovr_set_wins", {31'd0, overrun}, 1);
    idle(); idle(); idle();
    drive(0, 0, 0, 0, 0, 0, 1);

    cfg(1024, 1, 0, 1);   tk(16);
    cfg(16384, 0, 0, 1);  tk(1023); tk(512); tk(1); tk(512);

    cfg(1024, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 12, int'($urandom & 'hFFFF),
            int'($urandom_range(1, 3)), int'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 6);
    end
    repeat (4) idle();

    cfg(4096, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    reset = 1;
    #1;
    model_reset();
    check_eq("midrst_sample",  {22'd0, sample}, 512);
    check_eq("midrst_valid",   {31'd0, sample_valid}, 0);
    check_eq("midrst_busy",    {31'd0, busy}, 0);
    check_eq("midrst_overrun", {31'd0, overrun}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclk);
      #1;
      check_eq("midrst_hold_valid", {31'd0, sample_valid}, 0);
    end
    @(negedge sysclk);
    reset = 0;
    repeat (3) idle();
    cfg(1024, 1, 0, 0);  tk(16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/dds_wavegen.md
Name: dds_wavegen

Overview:
Parametrised direct-digital-synthesis waveform generator for the DAC/PWM signal path. It replaces the fixed address-counter plus sine-ROM arrangement with a phase accumulator. Frequency, waveform mode and attenuation are runtime inputs, and updates are applied glitch-free on sample boundaries. On each sample tick it produces one offset-binary sample with a valid strobe, which feeds spi2dac and pwm directly.

Parameters:
PHASE_W, 16, phase accumulator width (bits); must be ≥ DATA_W+1
DATA_W, 10, output sample width (offset binary, centre = 2^(DATA_W-1))
LUT_INIT, "sine_lut.mif", init file for the internal 2^DATA_W-entry sine table

Ports:
sysclk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
tick  in  1  sample strobe, one sysclk wide (from the tick generator)
freq_word  in  PHASE_W  phase increment per tick
mode  in  2  0=sine, 1=sawtooth, 2=square, 3=triangle
atten  in  3  arithmetic right-shift applied about centre (0 = full scale)
update  in  1  one-cycle pulse: capture freq_word/mode/atten into the pending registers
phase_clr  in  1  one-cycle pulse: zero the accumulator at the next tick
clr_overrun  in  1  clears the overrun flag
sample  out  DATA_W  current output sample
sample_valid  out  1  one-cycle pulse when sample updates
busy  out  1  high while the pipeline is in flight
overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset values (async, immediate):
  - acc=0; active/pending freq=0, mode=0, atten=0; update_pend=0; clr_pend=0.
  - sample = 2^(DATA_W-1) (512), sample_valid=0, busy=0, overrun=0.
- Parameter capture:
  - update pulse: copy inputs into the pending registers and set update_pend.
  - Pending → active transfer happens only on an accepted tick, before accumulation.
  - update and tick in the same cycle: the new values are used for that tick.
- Pipeline, for an accepted tick at cycle T:
  - T+1: if clr_pend, acc=freq_active (phase restarts from 0 then steps once); otherwise acc = acc + freq_active, mod 2^PHASE_W (wraps silently). clr_pend and update_pend are cleared. The LUT address p = acc[PHASE_W-1 -: DATA_W] is presented.
  - T+2: LUT data is registered (synchronous, one-cycle ROM). p and the active mode/atten are delayed in parallel to stay aligned.
  - T+3: the waveform is selected and attenuated, then registered into sample. sample_valid=1 for this cycle only.
  - Latency from tick to sample_valid is exactly 3 cycles. busy=1 during T+1..T+3.
- Waveforms, as raw DATA_W offset binary from p:
  - sine: LUT[p].
  - sawtooth: p.
  - square: p[MSB]=0 → all-ones (1023); otherwise 0.
  - triangle: t={p[DATA_W-2:0],1'b0}; p[MSB]=0 → t; otherwise ~t.
- Attenuation:
  - d = raw − centre, computed signed DATA_W+1 bits.
  - sample = centre + (d >>> atten).
  - The result is always in range, so no saturation is needed.
- Overrun:
  - A tick while busy=1 is ignored; acc is unchanged and overrun is set.
  - clr_overrun clears the flag. If clr_overrun and an overrun tick coincide, the set wins.
- phase_clr sets clr_pend. The flag persists until the next accepted tick.
- Reset asserted mid-pipeline: all stages are flushed, sample_valid is not emitted, and state returns to the reset values.

Decomposition:
- Package dds_pkg:
  - mode encodings MODE_SINE/SAW/SQUARE/TRI.
  - function for centre value.
  - pipeline latency constant DDS_LAT=3.
- Sub-module: sine_lut (2^DATA_W × DATA_W synchronous ROM, one-cycle read, initialised from LUT_INIT).

Test Plan:
- Reset mid-run: assert reset at T+2 of a tick → sample=512, sample_valid never pulses, busy=0, overrun=0 immediately.
- Sawtooth, PHASE_W=16, freq_word=1024, update, then 3 ticks:
  - valid exactly 3 cycles after each tick.
  - samples 16, 32, 48.
- Wrap:
  - freq_word=0x8000 saw, 2 ticks → acc 0x8000 then 0x0000, samples 512 then 0.
  - square mode gives 0 then 1023.
- Update timing: update freq_word=2048 in the cycle between ticks while saw at 16 → next sample 48 (16+32). No change before that tick.
- Attenuation: saw raw 16, atten=1 → sample 264. atten=7 → 512+(−496>>>7)=508.
- Overrun and phase_clr:
  - tick at T and T+2 → second tick ignored, overrun=1, acc advanced once.
  - clr_overrun → 0.
  - phase_clr then tick with freq 1024 → saw sample 16.
